midi_uart_tx: RTL and testbench

MIDI transmit path, the outbound counterpart of the uart_rx → poly_midi receive chain. Accepts one channel-voice event per handshake (note off, note on, program change) and builds the MIDI message bytes, with optional running-status compression. Serialises the bytes as UART 8N1 on a single TX line at the MIDI bit rate. Used to echo/forward events to an external MIDI device or to loop back into the synth's own receiver for self-test.

---
 rtl/midi_uart_tx.sv | 167 ++++++++++++++++
 tb/tb_midi_uart_tx.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/midi_uart_tx.sv
// MIDI channel-voice event transmitter: builds status/data bytes (with optional
// running status) and serialises them as UART 8N1 at CLKS_PER_BIT clocks per bit.
//
// state   | meaning
// S_IDLE  | line idle (TX=1), ready for an event
// S_START | start bit (TX=0)
// S_DATA  | 8 data bits, LSB first
// S_STOP  | stop bit (TX=1), then next byte or back to idle
module midi_uart_tx #(
  parameter int CLKS_PER_BIT   = 1600,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CE,
  input  logic       EV_VALID,
  output logic       EV_READY,
  input  logic [1:0] EV_TYPE,
  input  logic [3:0] CHANNEL,
  input  logic [6:0] DATA1,
  input  logic [6:0] DATA2,
  output logic       TX,
  output logic       BUSY
);

  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

  state_e            state_q, state_d;
  logic [BAUD_W-1:0] baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [1:0]        byte_q, byte_d;
  logic [1:0]        last_byte_q, last_byte_d;
  logic [7:0]        status_q, status_d;
  logic [6:0]        data1_q, data1_d;
  logic [6:0]        data2_q, data2_d;
  logic [7:0]        last_status_q, last_status_d;
  logic              last_valid_q, last_valid_d;
  logic              tx_q, tx_d;
  logic              busy_q, busy_d;

  logic       bit_done;
  logic [2:0] op;
  logic [7:0] new_status;
  logic       skip_status;
  logic [7:0] cur_byte;

  assign bit_done = (baud_q == BAUD_LAST);

  always_comb begin
    case (EV_TYPE)
      2'b01:   op = 3'b001;
      2'b10:   op = 3'b100;
      default: op = 3'b000;
    endcase
  end

  assign new_status  = {1'b1, op, CHANNEL};
  assign skip_status = RUNNING_STATUS && last_valid_q && (last_status_q == new_status);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= S_IDLE;
      baud_q        <= '0;
      bit_q         <= '0;
      byte_q        <= '0;
      last_byte_q   <= '0;
      status_q      <= '0;
      data1_q       <= '0;
      data2_q       <= '0;
      last_status_q <= '0;
      last_valid_q  <= 1'b0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
    end else if (CE) begin
      state_q       <= state_d;
      baud_q        <= baud_d;
      bit_q         <= bit_d;
      byte_q        <= byte_d;
      last_byte_q   <= last_byte_d;
      status_q      <= status_d;
      data1_q       <= data1_d;
      data2_q       <= data2_d;
      last_status_q <= last_status_d;
      last_valid_q  <= last_valid_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    baud_d        = baud_q;
    bit_d         = bit_q;
    byte_d        = byte_q;
    last_byte_d   = last_byte_q;
    status_d      = status_q;
    data1_d       = data1_q;
    data2_d       = data2_q;
    last_status_d = last_status_q;
    last_valid_d  = last_valid_q;
    if (state_q != S_IDLE) begin
      baud_d = bit_done ? '0 : baud_q + BAUD_W'(1);
    end
    case (state_q)
      S_IDLE: begin
        // Reserved type is swallowed here: handshake completes, FSM stays idle.
        if (EV_VALID && (EV_TYPE != 2'b11)) begin
          state_d       = S_START;
          baud_d        = '0;
          bit_d         = '0;
          status_d      = new_status;
          data1_d       = DATA1;
          data2_d       = DATA2;
          last_byte_d   = (EV_TYPE == 2'b10) ? 2'd1 : 2'd2;
          byte_d        = skip_status ? 2'd1 : 2'd0;
          last_status_d = new_status;
          last_valid_d  = 1'b1;
        end
      end
      S_START: begin
        if (bit_done) begin
          state_d = S_DATA;
          bit_d   = '0;
        end
      end
      S_DATA: begin
        if (bit_done) begin
          if (bit_q == 3'd7) state_d = S_STOP;
          else bit_d = bit_q + 3'd1;
        end
      end
      S_STOP: begin
        if (bit_done) begin
          if (byte_q == last_byte_q) begin
            state_d = S_IDLE;
          end else begin
            byte_d  = byte_q + 2'd1;
            state_d = S_START;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (byte_q)
      2'd0:    cur_byte = status_q;
      2'd1:    cur_byte = {1'b0, data1_q};
      default: cur_byte = {1'b0, data2_q};
    endcase
    case (state_q)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = cur_byte[bit_q];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  assign EV_READY = (state_q == S_IDLE);
  assign BUSY     = busy_q;
  assign TX       = tx_q;

endmodule

// File: tb/tb_midi_uart_tx.sv
// Directed bench for midi_uart_tx: decodes the TX line at bit centres and
// compares the bytes and handshake timing against hand-computed MIDI messages.
module tb_midi_uart_tx;

  localparam int CPB = 4;

  logic       clk;
  logic       rst;
  logic       ce;
  logic       ev_valid;
  logic       ev_valid_b;
  logic [1:0] ev_type;
  logic [3:0] channel;
  logic [6:0] data1;
  logic [6:0] data2;
  logic       tx_a, ready_a, busy_a;
  logic       tx_b, ready_b, busy_b;

  int checks = 0;
  int errors = 0;

  midi_uart_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b1)) dut_a (
    .CLK(clk), .RST(rst), .CE(ce), .EV_VALID(ev_valid), .EV_READY(ready_a),
    .EV_TYPE(ev_type), .CHANNEL(channel), .DATA1(data1), .DATA2(data2),
    .TX(tx_a), .BUSY(busy_a)
  );

  midi_uart_tx #(.CLKS_PER_BIT(CPB), .RUNNING_STATUS(1'b0)) dut_b (
    .CLK(clk), .RST(rst), .CE(ce), .EV_VALID(ev_valid_b), .EV_READY(ready_b),
    .EV_TYPE(ev_type), .CHANNEL(channel), .DATA1(data1), .DATA2(data2),
    .TX(tx_b), .BUSY(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_ready(input bit which);
    int cnt = 0;
    while (((which ? ready_b : ready_a) !== 1'b1) && cnt < 2000) begin
      @(negedge clk);
      cnt++;
    end
    checks++;
    if ((which ? ready_b : ready_a) !== 1'b1) begin
      errors++;
      $display("FAIL ready_timeout got %b exp 1", which ? ready_b : ready_a);
    end
  endtask

  // Called at a negedge; returns #1 after the acceptance edge.
  task automatic accept_event(input bit which, input logic [1:0] t, input logic [3:0] ch,
                              input logic [6:0] d1, input logic [6:0] d2, input bit hold);
    wait_ready(which);
    ev_type = t;
    channel = ch;
    data1   = d1;
    data2   = d2;
    ce      = 1'b1;
    if (which) ev_valid_b = 1'b1;
    else ev_valid = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) begin
      ev_valid   = 1'b0;
      ev_valid_b = 1'b0;
    end
  endtask

  // Samples one message after acceptance; s is the CE stretch factor (1 or 2).
  task automatic capture(input int nbytes, input int s, input bit which, input bit scramble,
                         output logic [2:0][7:0] got, output bit frame_ok,
                         output bit edge_ok, output bit busy_ok);
    int total;
    int rel;
    int b;
    int j;
    int k;
    logic t, bz, rd;
    total    = s * 10 * CPB * nbytes;
    got      = '0;
    frame_ok = 1'b1;
    edge_ok  = 1'b1;
    busy_ok  = 1'b1;
    for (int n = 0; n <= total; n++) begin
      @(negedge clk);
      t  = which ? tx_b : tx_a;
      bz = which ? busy_b : busy_a;
      rd = which ? ready_b : ready_a;
      if (n == 0 && (t !== 1'b1 || bz !== 1'b1 || rd !== 1'b0)) edge_ok = 1'b0;
      if (n == s - 1 && t !== 1'b1) edge_ok = 1'b0;
      if (n == s && t !== 1'b0) edge_ok = 1'b0;
      if (n < total && (bz !== 1'b1 || rd !== 1'b0)) busy_ok = 1'b0;
      if (n == total && (bz !== 1'b0 || rd !== 1'b1 || t !== 1'b1)) busy_ok = 1'b0;
      if (n >= s && n < total) begin
        rel = n - s;
        if (rel % (CPB * s) == 2 * s) begin
          b = rel / (CPB * s);
          j = b / 10;
          k = b % 10;
          if (k == 0) begin
            if (t !== 1'b0) frame_ok = 1'b0;
          end else if (k == 9) begin
            if (t !== 1'b1) frame_ok = 1'b0;
          end else begin
            got[j][k-1] = t;
          end
        end
      end
      if (s == 2) ce = ((n + 1) % 2 == 0);
      if (scramble) begin
        channel = 4'(n);
        data1   = 7'(n * 3);
        data2   = 7'(~n);
        ev_type = 2'(n);
      end
    end
    ce = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({tx_a, ready_a, busy_a} !== 3'b110) begin
      errors++;
      $display("FAIL reset_a tx/ready/busy got %b exp 110", {tx_a, ready_a, busy_a});
    end
    checks++;
    if ({tx_b, ready_b, busy_b} !== 3'b110) begin
      errors++;
      $display("FAIL reset_b tx/ready/busy got %b exp 110", {tx_b, ready_b, busy_b});
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_note_on;
    logic [2:0][7:0] got;
    bit f, e, bo;
    accept_event(1'b0, 2'b01, 4'd0, 7'd60, 7'd100, 1'b0);
    capture(3, 1, 1'b0, 1'b0, got, f, e, bo);
    checks++;
    if (got !== 24'h643C90) begin errors++; $display("FAIL note_on bytes got %h exp 643c90", got); end
    checks++;
    if (!f) begin errors++; $display("FAIL note_on framing got 0 exp 1"); end
    checks++;
    if (!e) begin errors++; $display("FAIL note_on start_latency got 0 exp 1"); end
    checks++;
    if (!bo) begin errors++; $display("FAIL note_on busy_120 got 0 exp 1"); end
  endtask

  task automatic test_back_to_back;
    logic [2:0][7:0] got;
    bit f, e, bo;
    accept_event(1'b0, 2'b01, 4'd0, 7'd64, 7'd0, 1'b0);
    capture(2, 1, 1'b0, 1'b0, got, f, e, bo);
    checks++;
    if (got !== 24'h000040) begin errors++; $display("FAIL running_status bytes got %h exp 000040", got); end
    checks++;
    if (!(f && e && bo)) begin errors++; $display("FAIL running_status timing got %b%b%b exp 111", f, e, bo); end
    accept_event(1'b0, 2'b00, 4'd0, 7'd64, 7'd64, 1'b0);
    capture(3, 1, 1'b0, 1'b0, got, f, e, bo);
    checks++;
    if (got !== 24'h404080) begin errors++; $display("FAIL note_off bytes got %h exp 404080", got); end
    checks++;
    if (!(f && e && bo)) begin errors++; $display("FAIL note_off timing got %b%b%b exp 111", f, e, bo); end
  endtask

  task automatic test_program_change;
    logic [2:0][7:0] got;
    bit f, e, bo;
    accept_event(1'b0, 2'b10, 4'd9, 7'd5, 7'h7F, 1'b0);
    capture(2, 1, 1'b0, 1'b0, got, f, e, bo);
    checks++;
    if (got !== 24'h0005C9) begin errors++; $display("FAIL prog_change bytes got %h exp 0005c9", got); end
    checks++;
    if (!(f && e && bo)) begin errors++; $display("FAIL prog_change timing got %b%b%b exp 111", f, e, bo); end
    accept_event(1'b0, 2'b10, 4'd9, 7'd5, 7'h7F, 1'b0);
    capture(1, 1, 1'b0, 1'b0, got, f, e, bo);
    checks++;
    if (got !== 24'h000005) begin errors++; $display("FAIL prog_repeat_rs bytes got %h exp 000005", got); end
    for (int r = 0; r < 2; r++) begin
      accept_event(1'b1, 2'b10, 4'd9, 7'd5, 7'h7F, 1'b0);
      capture(2, 1, 1'b1, 1'b0, got, f, e, bo);
      checks++;
      if (got !== 24'h0005C9) begin errors++; $display("FAIL prog_no_rs_%0d bytes got %h exp 0005c9", r, got); end
      checks++;
      if (!(f && e && bo)) begin errors++; $display("FAIL prog_no_rs_%0d timing got %b%b%b exp 111", r, f, e, bo); end
    end
  endtask

  task automatic test_reserved;
    logic [2:0][7:0] got;
    bit f, e, bo;
    bit ok = 1'b1;
    accept_event(1'b0, 2'b11, 4'd9, 7'h11, 7'h22, 1'b0);
    repeat (6) begin
      @(negedge clk);
      if ({tx_a, ready_a, busy_a} !== 3'b110) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL reserved_idle got %b exp 110", {tx_a, ready_a, busy_a}); end
    accept_event(1'b0, 2'b10, 4'd9, 7'd6, 7'd0, 1'b0);
    capture(1, 1, 1'b0, 1'b0, got, f, e, bo);
    checks++;
    if (got !== 24'h000006) begin errors++; $display("FAIL reserved_keeps_status bytes got %h exp 000006", got); end
  endtask

  task automatic test_valid_held;
    logic [2:0][7:0] got;
    bit f, e, bo;
    accept_event(1'b0, 2'b01, 4'd3, 7'd1, 7'd2, 1'b1);
    capture(3, 1, 1'b0, 1'b1, got, f, e, bo);
    checks++;
    if (got !== 24'h020193) begin errors++; $display("FAIL valid_held_first bytes got %h exp 020193", got); end
    checks++;
    if (!(f && e && bo)) begin errors++; $display("FAIL valid_held_first timing got %b%b%b exp 111", f, e, bo); end
    accept_event(1'b0, 2'b01, 4'd3, 7'h55, 7'h2A, 1'b0);
    capture(2, 1, 1'b0, 1'b0, got, f, e, bo);
    checks++;
    if (got !== 24'h002A55) begin errors++; $display("FAIL valid_held_second bytes got %h exp 002a55", got); end
  endtask

  task automatic test_ce_toggle;
    logic [2:0][7:0] got;
    bit f, e, bo;
    bit ok = 1'b1;
    ce       = 1'b0;
    ev_type  = 2'b01;
    channel  = 4'd5;
    data1    = 7'h12;
    data2    = 7'h34;
    ev_valid = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if ({tx_a, ready_a, busy_a} !== 3'b110) ok = 1'b0;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL ce_low_no_accept got %b exp 110", {tx_a, ready_a, busy_a}); end
    accept_event(1'b0, 2'b01, 4'd5, 7'h12, 7'h34, 1'b0);
    capture(3, 2, 1'b0, 1'b0, got, f, e, bo);
    checks++;
    if (got !== 24'h341295) begin errors++; $display("FAIL ce_toggle bytes got %h exp 341295", got); end
    checks++;
    if (!f) begin errors++; $display("FAIL ce_toggle framing got 0 exp 1"); end
    checks++;
    if (!(e && bo)) begin errors++; $display("FAIL ce_toggle stretch got %b%b exp 11", e, bo); end
  endtask

  task automatic test_reset_mid_frame;
    logic [2:0][7:0] got;
    bit f, e, bo;
    accept_event(1'b0, 2'b01, 4'd0, 7'd1, 7'd2, 1'b0);
    repeat (60) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin errors++; $display("FAIL reset_mid_pre busy got %b exp 1", busy_a); end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({tx_a, ready_a, busy_a} !== 3'b110) begin
      errors++;
      $display("FAIL reset_mid tx/ready/busy got %b exp 110", {tx_a, ready_a, busy_a});
    end
    rst = 1'b0;
    @(negedge clk);
    accept_event(1'b0, 2'b01, 4'd0, 7'd60, 7'd100, 1'b0);
    capture(3, 1, 1'b0, 1'b0, got, f, e, bo);
    checks++;
    if (got !== 24'h643C90) begin errors++; $display("FAIL reset_clears_status bytes got %h exp 643c90", got); end
    checks++;
    if (!(f && e && bo)) begin errors++; $display("FAIL reset_clears_status timing got %b%b%b exp 111", f, e, bo); end
  endtask

  initial begin
    rst        = 1'b1;
    ce         = 1'b1;
    ev_valid   = 1'b0;
    ev_valid_b = 1'b0;
    ev_type    = 2'b00;
    channel    = 4'd0;
    data1      = 7'd0;
    data2      = 7'd0;
    test_reset();
    test_note_on();
    test_back_to_back();
    test_program_change();
    test_reserved();
    test_valid_held();
    test_ce_toggle();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
